// File: rtl/param_stack.sv
// Parametrised LIFO stack with registered top-of-stack, occupancy count and full/empty flags.
// Define STACK_ERR_EN to build the sticky overflow/underflow flag on err_o.
module param_stack #(
   parameter  int unsigned BUSWIDTH = 8,
   parameter  int unsigned DEPTH    = 16,
   localparam int unsigned CNTWIDTH = $clog2(DEPTH + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                push_i,
   input  logic                pop_i,
   input  logic [BUSWIDTH-1:0] data_i,
   output logic [BUSWIDTH-1:0] top_o,
   output logic [CNTWIDTH-1:0] count_o,
   output logic                empty_o,
   output logic                full_o,
   output logic                err_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [BUSWIDTH-1:0] mem [DEPTH];

   logic [CNTWIDTH-1:0] sp_q, sp_d;
   logic [BUSWIDTH-1:0] top_q, top_d;
   logic                empty_q, full_q;
   logic                we;
   logic [AW-1:0]       wr_addr;
   logic [AW-1:0]       rd_addr;

   // Word that becomes the new top after a pop from sp >= 2.
   assign rd_addr = AW'(sp_q - CNTWIDTH'(2));

   always_comb begin
      sp_d    = sp_q;
      top_d   = top_q;
      we      = 1'b0;
      wr_addr = AW'(sp_q);
      if (push_i && pop_i && !empty_q) begin
         // Replace the current top in place; occupancy unchanged.
         we      = 1'b1;
         wr_addr = AW'(sp_q - CNTWIDTH'(1));
         top_d   = data_i;
      end else if (push_i) begin
         if (!full_q) begin
            we    = 1'b1;
            sp_d  = sp_q + CNTWIDTH'(1);
            top_d = data_i;
         end
      end else if (pop_i) begin
         if (!empty_q) begin
            sp_d = sp_q - CNTWIDTH'(1);
            if (sp_q == CNTWIDTH'(1)) begin
               top_d = '0;
            end else begin
               top_d = mem[rd_addr];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sp_q    <= '0;
         top_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         top_q   <= top_d;
         empty_q <= (sp_d == '0);
         full_q  <= (sp_d == CNTWIDTH'(DEPTH));
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i && we) begin
         mem[wr_addr] <= data_i;
      end
   end

`ifdef STACK_ERR_EN
   logic err_q;
   logic overflow;
   logic underflow;

   assign overflow  = push_i && !pop_i && full_q;
   assign underflow = pop_i && !push_i && empty_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (overflow || underflow) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign top_o   = top_q;
   assign count_o = sp_q;
   assign empty_o = empty_q;
   assign full_o  = full_q;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: directed plan steps plus random traffic against a queue model.
module tb_param_stack;

   localparam int unsigned BW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst, push, pop;
   logic [BW-1:0] data;
   logic [BW-1:0] top;
   logic [CW-1:0] count;
   logic          empty, full, err;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [BW-1:0] model_q[$];
   logic          model_err;

   param_stack #(.BUSWIDTH(BW), .DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (data),
      .top_o   (top),
      .count_o (count),
      .empty_o (empty),
      .full_o  (full),
      .err_o   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stack semantics expressed directly on a queue; back of queue is the top.
   task automatic model_step(input logic r, input logic pu, input logic po, input logic [BW-1:0] d);
      if (r) begin
         model_q.delete();
         model_err = 1'b0;
      end else if (pu && po && model_q.size() > 0) begin
         model_q[model_q.size() - 1] = d;
      end else if (pu) begin
         if (model_q.size() < DEPTH) model_q.push_back(d);
         else model_err = 1'b1;
      end else if (po) begin
         if (model_q.size() > 0) void'(model_q.pop_back());
         else model_err = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      logic [BW-1:0] exp_top;
      logic          exp_err;
      exp_top = (model_q.size() > 0) ? model_q[model_q.size() - 1] : '0;
`ifdef STACK_ERR_EN
      exp_err = model_err;
`else
      exp_err = 1'b0;
`endif
      chk({tag, ".top"},   32'(top),   32'(exp_top));
      chk({tag, ".count"}, 32'(count), 32'(model_q.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
      chk({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
      chk({tag, ".err"},   32'(err),   32'(exp_err));
   endtask

   // One clock: drive inputs, take the edge, sample 1 time unit later.
   task automatic cyc(input string tag, input logic r, input logic pu, input logic po,
                      input logic [BW-1:0] d);
      rst  = r;
      push = pu;
      pop  = po;
      data = d;
      @(posedge clk);
      #1;
      model_step(r, pu, po, d);
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; data = '0;
      model_q.delete();
      model_err = 1'b0;

      // Reset then idle
      cyc("rst0", 1, 0, 0, 8'h00);
      cyc("rst1", 1, 0, 0, 8'h00);
      cyc("idle", 0, 0, 0, 8'h00);

      // Push/pop order
      cyc("push11", 0, 1, 0, 8'h11);
      cyc("push22", 0, 1, 0, 8'h22);
      cyc("push33", 0, 1, 0, 8'h33);
      chk("order.top33", 32'(top), 32'h33);
      chk("order.cnt3", 32'(count), 32'd3);
      cyc("pop1", 0, 0, 1, 8'h00);
      chk("order.top22", 32'(top), 32'h22);
      cyc("pop2", 0, 0, 1, 8'h00);
      chk("order.top11", 32'(top), 32'h11);
      cyc("pop3", 0, 0, 1, 8'h00);
      chk("order.top00", 32'(top), 32'h00);
      chk("order.empty", 32'(empty), 32'd1);

      // Fill and overflow
      for (int i = 0; i < 16; i++) cyc("fill", 0, 1, 0, 8'(i));
      chk("fill.full", 32'(full), 32'd1);
      chk("fill.top0f", 32'(top), 32'h0F);
      cyc("ovf", 0, 1, 0, 8'hAA);
      chk("ovf.cnt16", 32'(count), 32'd16);
      chk("ovf.top0f", 32'(top), 32'h0F);
      // Replace when full: no error added
      cyc("rst_f", 1, 0, 0, 8'h00);
      for (int i = 0; i < 16; i++) cyc("fill2", 0, 1, 0, 8'(i + 8'h40));
      cyc("repl_full", 0, 1, 1, 8'h5A);
      cyc("pop_after_repl_full", 0, 0, 1, 8'h00);
      chk("repl_full.top4e", 32'(top), 32'h4E);

      // Underflow, then err stays through a valid push
      cyc("rst_u", 1, 0, 0, 8'h00);
      cyc("unf", 0, 0, 1, 8'h00);
      cyc("push_after_unf", 0, 1, 0, 8'h99);

      // Simultaneous push+pop
      cyc("rst_s", 1, 0, 0, 8'h00);
      cyc("s_push11", 0, 1, 0, 8'h11);
      cyc("s_push22", 0, 1, 0, 8'h22);
      cyc("s_repl", 0, 1, 1, 8'h5A);
      chk("repl.top5a", 32'(top), 32'h5A);
      cyc("s_pop", 0, 0, 1, 8'h00);
      chk("repl.top11", 32'(top), 32'h11);
      cyc("s_pop2", 0, 0, 1, 8'h00);
      cyc("s_both_empty", 0, 1, 1, 8'h5A);
      chk("both_empty.cnt1", 32'(count), 32'd1);

      // Reset mid-operation
      for (int i = 0; i < 4; i++) cyc("m_push", 0, 1, 0, 8'(i + 1));
      cyc("m_rst_push", 1, 1, 0, 8'hEE);
      chk("mid.cnt0", 32'(count), 32'd0);
      cyc("m_push77", 0, 1, 0, 8'h77);
      chk("mid.top77", 32'(top), 32'h77);

      // Random traffic: push-heavy first half, pop-heavy second half
      for (int i = 0; i < 600; i++) begin
         int unsigned pp;
         logic        r, pu, po;
         pp = (i < 300) ? 70 : 30;
         r  = ($urandom_range(0, 99) < 2);
         pu = ($urandom_range(0, 99) < pp);
         po = ($urandom_range(0, 99) < 50);
         cyc("rand", r, pu, po, 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
